// File: rtl/ghost_chase.sv
// Ghost movement engine for the 8x8 grid: steps one cell per tick toward the
// scatter corner or Pac-Man, alternating phases on step counts and freezing outside PLAY.
module ghost_chase #(
  parameter logic [2:0] GHOST_X0      = 3'd7,
  parameter logic [2:0] GHOST_Y0      = 3'd7,
  parameter logic [2:0] CORNER_X      = 3'd0,
  parameter logic [2:0] CORNER_Y      = 3'd7,
  parameter int         SCATTER_STEPS = 8,
  parameter int         CHASE_STEPS   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_en,
  input  logic [1:0] State,
  input  logic [2:0] PacMan_x,
  input  logic [2:0] PacMan_y,
  output logic [2:0] ghost_x,
  output logic [2:0] ghost_y,
  output logic [1:0] ghost_dir,
  output logic [1:0] mode,
  output logic       moved
);

  localparam logic [1:0] MODE_SCATTER = 2'd0;
  localparam logic [1:0] MODE_CHASE   = 2'd1;
  localparam logic [1:0] MODE_FROZEN  = 2'd2;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic [7:0] SCATTER_LAST = 8'(SCATTER_STEPS - 1);
  localparam logic [7:0] CHASE_LAST   = 8'(CHASE_STEPS - 1);

  logic [2:0] gx_q, gx_d, gy_q, gy_d;
  logic [1:0] dir_q, dir_d, mode_q, mode_d;
  logic       moved_q, moved_d;
  logic       phase_q, phase_d;   // resume phase: 0 = scatter, 1 = chase
  logic [7:0] cnt_q, cnt_d;

  logic       play;
  logic [2:0] tx, ty, dx, dy;
  logic [7:0] last_cnt;

  always_comb begin
    gx_d    = gx_q;
    gy_d    = gy_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    moved_d = 1'b0;
    phase_d = phase_q;
    cnt_d   = cnt_q;

    play     = (State == 2'd0);
    tx       = phase_q ? PacMan_x : CORNER_X;
    ty       = phase_q ? PacMan_y : CORNER_Y;
    dx       = (tx >= gx_q) ? (tx - gx_q) : (gx_q - tx);
    dy       = (ty >= gy_q) ? (ty - gy_q) : (gy_q - ty);
    last_cnt = phase_q ? CHASE_LAST : SCATTER_LAST;

    if (!play) begin
      mode_d = MODE_FROZEN;
    end else begin
      if (step_en) begin
        // Ties favour the x axis; on-target steps hold but still count.
        if ((dx >= dy) && (dx != 3'd0)) begin
          moved_d = 1'b1;
          if (tx > gx_q) begin
            gx_d  = gx_q + 3'd1;
            dir_d = DIR_RIGHT;
          end else begin
            gx_d  = gx_q - 3'd1;
            dir_d = DIR_LEFT;
          end
        end else if (dy != 3'd0) begin
          moved_d = 1'b1;
          if (ty > gy_q) begin
            gy_d  = gy_q + 3'd1;
            dir_d = DIR_DOWN;
          end else begin
            gy_d  = gy_q - 3'd1;
            dir_d = DIR_UP;
          end
        end

        if (cnt_q == last_cnt) begin
          cnt_d   = 8'd0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      mode_d = phase_d ? MODE_CHASE : MODE_SCATTER;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gx_q    <= GHOST_X0;
      gy_q    <= GHOST_Y0;
      dir_q   <= DIR_LEFT;
      mode_q  <= MODE_SCATTER;
      moved_q <= 1'b0;
      phase_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      moved_q <= moved_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ghost_x   = gx_q;
  assign ghost_y   = gy_q;
  assign ghost_dir = dir_q;
  assign mode      = mode_q;
  assign moved     = moved_q;

endmodule
